// File: rtl/operand_mux.sv
// Registered ALU second-operand select: register-file value or extended immediate.
// Honours pipeline stall/flush; imm_ext is a combinational side output for branch/address units.
module operand_mux #(
    parameter int unsigned data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           in_immediate,
    input  logic [data_width-1:0] in_reg,
    input  logic                  select,
    input  logic [1:0]            ext_mode,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic [data_width-1:0] out,
    output logic                  out_valid,
    output logic [data_width-1:0] imm_ext
);

    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_RSVD  = 2'b11
    } ext_mode_t;

    ext_mode_t             mode;
    logic [data_width-1:0] sel_val;

    assign mode = ext_mode_t'(ext_mode);

    // Reserved encoding falls through to sign extension.
    always_comb begin
        imm_ext = data_width'(signed'(in_immediate));
        case (mode)
            EXT_ZERO:  imm_ext = data_width'(in_immediate);
            EXT_UPPER: imm_ext = data_width'(in_immediate) << (data_width - 16);
            default:   ;
        endcase
    end

    assign sel_val = select ? imm_ext : in_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                out       <= sel_val;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_mux.sv
// Scoreboard bench for operand_mux: driver pushes model expectations, monitor pops after each edge.
module tb_operand_mux;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  in_immediate;
    logic [W-1:0] in_reg;
    logic         select;
    logic [1:0]   ext_mode;
    logic         in_valid;
    logic         stall;
    logic         flush;
    logic [W-1:0] out;
    logic         out_valid;
    logic [W-1:0] imm_ext;

    operand_mux #(.data_width(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_immediate (in_immediate),
        .in_reg       (in_reg),
        .select       (select),
        .ext_mode     (ext_mode),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .out          (out),
        .out_valid    (out_valid),
        .imm_ext      (imm_ext)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        logic         v;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks = 0;
    int           fails  = 0;
    logic [W-1:0] m_out;
    logic         m_valid;

    // Reference extension using plain arithmetic on the immediate's numeric value.
    function automatic logic [W-1:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint unsigned v;
        longint unsigned r;
        v = 64'(imm);
        case (mode)
            2'b01:   r = v;
            2'b10:   r = v * (64'd1 << (W - 16));
            default: r = (v >= 64'd32768) ? v + ((64'd1 << W) - 64'd65536) : v;
        endcase
        return W'(r);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic sel, input logic [15:0] imm, input logic [W-1:0] rv,
                         input logic [1:0] mode, input logic iv, input logic st,
                         input logic fl, input string tag);
        @(negedge clk);
        select = sel; in_immediate = imm; in_reg = rv; ext_mode = mode;
        in_valid = iv; stall = st; flush = fl;
        #1;
        check({tag, "_imm_ext"}, imm_ext, ref_ext(imm, mode));
        if (fl) begin
            m_out = '0;
            m_valid = 1'b0;
        end else if (!st) begin
            if (iv) begin
                m_out = sel ? ref_ext(imm, mode) : rv;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        sb.push_back('{m_out, m_valid, tag});
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check({mon_e.tag, "_out"}, out, mon_e.o);
            check({mon_e.tag, "_valid"}, W'(out_valid), W'(mon_e.v));
        end
    end

    initial begin
        rst_n = 1'b0;
        in_immediate = '0; in_reg = '0; select = 1'b0; ext_mode = 2'b00;
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        m_out = '0; m_valid = 1'b0;
        #1;
        check("reset_out", out, '0);
        check("reset_valid", W'(out_valid), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b0, 16'd4096, 32'd94035, 2'b00, 1'b1, 1'b0, 1'b0, "sel_reg");
        drive(1'b1, 16'd4096, 32'd94035, 2'b00, 1'b1, 1'b0, 1'b0, "sel_imm");

        for (int m = 0; m < 4; m++)
            drive(1'b1, 16'h8000, 32'h1234_5678, 2'(m), 1'b1, 1'b0, 1'b0, "ext_mode");
        drive(1'b1, 16'h7FFF, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, "ext_pos");
        drive(1'b1, 16'hFFFF, 32'h0, 2'b10, 1'b1, 1'b0, 1'b0, "ext_upper_ff");

        drive(1'b0, 16'd0, 32'd94035, 2'b00, 1'b1, 1'b0, 1'b0, "stall_load");
        for (int i = 0; i < 3; i++)
            drive(i[0], 16'($urandom), $urandom, 2'($urandom), 1'b1, 1'b1, 1'b0, "stall_hold");
        drive(1'b0, 16'd0, 32'd1234, 2'b00, 1'b1, 1'b0, 1'b0, "stall_release");

        drive(1'b0, 16'd0, 32'd555, 2'b00, 1'b1, 1'b1, 1'b1, "flush_stall");
        drive(1'b0, 16'd0, 32'd556, 2'b00, 1'b1, 1'b0, 1'b1, "flush_valid");

        drive(1'b1, 16'd4096, 32'd9, 2'b00, 1'b1, 1'b0, 1'b0, "bubble_load");
        drive(1'b1, 16'd1, 32'd9, 2'b00, 1'b0, 1'b0, 1'b0, "bubble");

        drive(1'b0, 16'd0, 32'd94035, 2'b00, 1'b1, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", out, '0);
        check("async_rst_valid", W'(out_valid), '0);
        @(posedge clk);
        #1;
        check("rst_held_out", out, '0);
        #1 rst_n = 1'b1;
        m_out = '0; m_valid = 1'b0;
        drive(1'b0, 16'd0, 32'd777, 2'b00, 1'b1, 1'b0, 1'b0, "post_rst");

        for (int i = 0; i < 300; i++)
            drive(1'($urandom), 16'($urandom), $urandom, 2'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0), "rand");

        @(posedge clk);
        #3;
        check("sb_drained", W'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/operand_mux.md
# operand_mux

Registered ALU operand-select stage for the pipelined datapath. Each cycle it picks the second ALU operand: either the register-file value or the 16-bit instruction immediate, extended to `data_width` bits. The choice is captured in a pipeline register. It sits between decode (register read and immediate field) and execute, and honours the pipeline stall and flush controls.

## Interface
Parameters:
- `data_width`, default 32, operand width; must be ≥ 16.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_immediate`  in  16  raw immediate field from the instruction.
- `in_reg`  in  `data_width`  register-file operand.
- `select`  in  1  0 = register operand, 1 = extended immediate.
- `ext_mode`  in  2  immediate extension: 00 sign, 01 zero, 10 upper, 11 reserved.
- `in_valid`  in  1  the upstream stage holds a real instruction.
- `stall`  in  1  1 = hold the output register.
- `flush`  in  1  1 = squash the stage (insert a bubble).
- `out`  out  `data_width`  registered selected operand.
- `out_valid`  out  1  registered valid that accompanies `out`.
- `imm_ext`  out  `data_width`  combinational extended immediate, for the branch and address units.

## Operation
- Extension of `in_immediate` into `imm_ext`:
  - Sign (00): bit 15 replicated into bits [`data_width`-1:16].
  - Zero (01): bits [`data_width`-1:16] = 0.
  - Upper (10): immediate placed in bits [`data_width`-1:`data_width`-16]; all lower bits = 0. For width 32 this is `imm << 16`.
  - Reserved (11): behaves exactly as sign (00).
- Combinational selection: `sel_val = select ? imm_ext : in_reg`.
- Register update priority, on each rising edge when `rst_n` = 1:
  1. `flush` = 1 → `out` ← 0, `out_valid` ← 0. Flush overrides stall.
  2. else `stall` = 1 → `out` and `out_valid` hold.
  3. else `in_valid` = 1 → `out` ← `sel_val`, `out_valid` ← 1.
  4. else → `out` holds, `out_valid` ← 0.
- Arithmetic: none. The block is pure selection and extension, with no carries.
- `imm_ext` depends only on `in_immediate` and `ext_mode`. It is independent of clock, reset, stall and flush.

## Timing
- Reset: while `rst_n` = 0, `out` = 0 and `out_valid` = 0, immediately (asynchronous), and they stay there. Release is sampled at the next rising edge.
- Reset mid-operation: clears both outputs at once; any in-flight value is lost.
- Latency: 1 cycle from inputs sampled at edge N to `out`/`out_valid` after edge N.
- Throughput: one operand per cycle when not stalled.
- `imm_ext`: zero-latency combinational path.
- Simultaneous `stall` and `flush`: flush wins and produces a bubble.
- Simultaneous `flush` and `in_valid`: the input is dropped.
- Inputs changing mid-cycle: no effect until the next edge, except on `imm_ext`.

## Test plan
- Basic select: `in_immediate` = 4096, `in_reg` = 94035, `ext_mode` = 00, `in_valid` = 1.
  - `select` = 0 → after one edge, `out` = 94035, `out_valid` = 1.
  - `select` = 1 → after the next edge, `out` = 4096.
- Extension modes with `in_immediate` = 0x8000 and `select` = 1:
  - `ext_mode` 00 → `out` = 0xFFFF8000.
  - 01 → 0x00008000.
  - 10 → 0x80000000.
  - 11 → 0xFFFF8000.
  - `imm_ext` shows the same values before the edge.
- Stall hold: load 94035, then `stall` = 1 for 3 cycles while the inputs change → `out` stays 94035 and `out_valid` stays 1. Drop `stall` → the new value appears one edge later.
- Flush priority: `stall` = 1 and `flush` = 1 on the same edge → `out` = 0 and `out_valid` = 0 after the edge.
- Bubble: `in_valid` = 0 after a valid load of 4096 → `out_valid` = 0 and `out` holds 4096.
- Async reset: assert `rst_n` = 0 mid-cycle while `out` = 94035 → `out` = 0 and `out_valid` = 0 with no clock edge. After release, the first valid input appears after one edge.
